// File: rtl/cla_serial_subtractor.sv
// -----------------------------------------------------------------------------
// cla_serial_subtractor
//
// Multi-cycle two's-complement subtractor: D = A - B - B_in on WIDTH-bit
// operands, one 4-bit nibble per clock, least-significant nibble first.
// Each nibble is a carry-look-ahead slice computing A_nib + ~B_nib + carry,
// so the first carry is ~B_in and the final borrow is the inverted carry out.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands present on A, B, B_in
//   in_ready   block can accept operands (high only in IDLE)
//   A, B       minuend / subtrahend, WIDTH bits
//   B_in       borrow in
//   out_valid  result valid (high only in DONE)
//   out_ready  consumer accepts result
//   D          difference, WIDTH bits
//   B_out      borrow out: 1 when unsigned A < B + B_in
//   OVF        signed overflow
//   Z          (only with CLA_SUB_ZERO_FLAG_EN) 1 when final D == 0
//
// Optional feature macro: CLA_SUB_ZERO_FLAG_EN adds the zero flag output Z.
// -----------------------------------------------------------------------------
module cla_serial_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             B_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic             B_out,
`ifdef CLA_SUB_ZERO_FLAG_EN
  output logic             Z,
`endif
  output logic             OVF
);

  localparam int NIB   = WIDTH / 4;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   d_q, d_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic               bout_q, bout_d;
  logic               ovf_q, ovf_d;
`ifdef CLA_SUB_ZERO_FLAG_EN
  logic               z_q, z_d;
`endif

  // Current nibble slice: operand B is inverted so the adder performs A - B.
  logic [IDX_W+1:0] bit_base;
  logic [3:0]       a_nib, nb_nib, g, p, c, s;
  logic             c_out;

  assign bit_base = {idx_q, 2'b00};
  assign a_nib    = a_q[bit_base +: 4];
  assign nb_nib   = ~b_q[bit_base +: 4];
  assign g        = a_nib & nb_nib;
  assign p        = a_nib ^ nb_nib;

  // Look-ahead carries; c[3] is the carry into the nibble's top bit, which
  // on the last nibble is the carry into bit WIDTH-1 used for overflow.
  assign c[0]  = carry_q;
  assign c[1]  = g[0] | (p[0] & carry_q);
  assign c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry_q);
  assign c[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & carry_q);
  assign c_out = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & carry_q);
  assign s     = p ^ c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      d_q     <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef CLA_SUB_ZERO_FLAG_EN
      z_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      d_q     <= d_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
`ifdef CLA_SUB_ZERO_FLAG_EN
      z_q     <= z_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    d_d     = d_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
`ifdef CLA_SUB_ZERO_FLAG_EN
    z_d     = z_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = A;
          b_d     = B;
          carry_d = ~B_in;
          idx_d   = '0;
`ifdef CLA_SUB_ZERO_FLAG_EN
          z_d     = 1'b1;
`endif
          state_d = RUN;
        end
      end
      RUN: begin
        d_d[bit_base +: 4] = s;
        carry_d            = c_out;
        idx_d              = idx_q + 1'b1;
`ifdef CLA_SUB_ZERO_FLAG_EN
        z_d                = z_q & (s == 4'h0);
`endif
        if (idx_q == LAST_IDX) begin
          bout_d  = ~c_out;
          ovf_d   = c[3] ^ c_out;
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign D         = d_q;
  assign B_out     = bout_q;
  assign OVF       = ovf_q;
`ifdef CLA_SUB_ZERO_FLAG_EN
  assign Z         = z_q;
`endif

endmodule

// File: tb/tb_cla_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_cla_serial_subtractor
//
// Self-checking bench for cla_serial_subtractor at WIDTH=16: a table of
// directed vectors with hand-computed results, plus hand-written sequences
// for output stall, ignored input during stall, and asynchronous mid-op reset.
// -----------------------------------------------------------------------------
module tb_cla_serial_subtractor;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A, B;
  logic         B_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] D;
  logic         B_out;
  logic         OVF;
`ifdef CLA_SUB_ZERO_FLAG_EN
  logic         Z;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  cla_serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .B_in      (B_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .D         (D),
    .B_out     (B_out),
`ifdef CLA_SUB_ZERO_FLAG_EN
    .Z         (Z),
`endif
    .OVF       (OVF)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] d;
    logic        bout;
    logic        ovf;
    logic        z;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Presents operands, waits for out_valid (bounded), checks latency and
  // in_ready during the operation. Leaves the DUT in DONE, sampled #1 after edge.
  task automatic start_and_wait(input logic [15:0] a, input logic [15:0] b,
                                input logic bin, input string tag);
    int n;
    @(negedge clk);
    chk({tag, " in_ready idle"}, in_ready, 1'b1);
    A = a; B = b; B_in = bin; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      if (in_ready !== 1'b0) begin
        n_cmp++; n_fail++;
        $display("FAIL %s in_ready busy: got %0b, expected 0 at edge %0d", tag, in_ready, n);
      end
      @(posedge clk); #1;
      n++;
    end
    chk({tag, " latency"}, n, 4);
    chk({tag, " in_ready done"}, in_ready, 1'b0);
  endtask

  task automatic check_result(input vec_t v, input string tag);
    chk({tag, " D"}, D, v.d);
    chk({tag, " B_out"}, B_out, v.bout);
    chk({tag, " OVF"}, OVF, v.ovf);
`ifdef CLA_SUB_ZERO_FLAG_EN
    chk({tag, " Z"}, Z, v.z);
`endif
  endtask

  task automatic release_result(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, " out_valid drop"}, out_valid, 1'b0);
    chk({tag, " in_ready back"}, in_ready, 1'b1);
  endtask

  initial begin
    vecs[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{16'h0005, 16'h0003, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{16'h00A5, 16'h00A5, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; B_in = 1'b0;
    #12;
    chk("reset in_ready", in_ready, 1'b1);
    chk("reset out_valid", out_valid, 1'b0);
    chk("reset D", D, 16'h0000);
    chk("reset B_out", B_out, 1'b0);
    chk("reset OVF", OVF, 1'b0);
`ifdef CLA_SUB_ZERO_FLAG_EN
    chk("reset Z", Z, 1'b0);
`endif
    @(negedge clk); rst_n = 1'b1;

    // Table-driven vectors (last entry reserved for the stall sequence).
    for (int i = 0; i < 7; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      start_and_wait(vecs[i].a, vecs[i].b, vecs[i].bin, tag);
      check_result(vecs[i], tag);
      release_result(tag);
    end

    // Stall in DONE for 3 cycles with a stray in_valid pulse that must be ignored.
    start_and_wait(vecs[7].a, vecs[7].b, vecs[7].bin, "stall");
    check_result(vecs[7], "stall");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 1) begin
        A = 16'h1111; B = 16'h0001; B_in = 1'b0; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      chk($sformatf("stall%0d out_valid", k), out_valid, 1'b1);
      chk($sformatf("stall%0d in_ready", k), in_ready, 1'b0);
      chk($sformatf("stall%0d D", k), D, 16'h0000);
      chk($sformatf("stall%0d B_out", k), B_out, 1'b0);
    end
    in_valid = 1'b0;
    check_result(vecs[7], "stall end");
    release_result("stall");
    // The pulse during the stall must not have started an operation.
    @(posedge clk); #1;
    chk("stall no restart", in_ready, 1'b1);

    // Mid-op reset: abort after 2 RUN edges.
    @(negedge clk);
    A = 16'hFFFF; B = 16'h0001; B_in = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    chk("midrst partial D", D, 16'h00FE);
    rst_n = 1'b0;
    #1;
    chk("midrst in_ready", in_ready, 1'b1);
    chk("midrst out_valid", out_valid, 1'b0);
    chk("midrst D", D, 16'h0000);
    chk("midrst B_out", B_out, 1'b0);
    chk("midrst OVF", OVF, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    begin
      vec_t v;
      v = '{16'h0010, 16'h0001, 1'b0, 16'h000F, 1'b0, 1'b0, 1'b0};
      start_and_wait(v.a, v.b, v.bin, "postrst");
      check_result(v, "postrst");
      release_result("postrst");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
